// File: rtl/wb_cdb_arbiter.sv
// Completion-side arbiter: buffers finished results from each functional unit in a small
// per-source FIFO and serialises them onto one registered common data bus (CDB).
// Results addressed to r0 are accepted but discarded; drop_cnt counts them.
module wb_cdb_arbiter #(
   parameter int unsigned N_SRC = 8,
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned SW    = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_SRC-1:0]       src_valid,
   output logic [N_SRC-1:0]       src_ready,
   input  logic [5*N_SRC-1:0]     src_rd,
   input  logic [DW*N_SRC-1:0]    src_data,
   output logic                   cdb_valid,
   input  logic                   cdb_ready,
   output logic [SW-1:0]          cdb_src,
   output logic [4:0]             cdb_rd,
   output logic [DW-1:0]          cdb_data,
   output logic [15:0]            drop_cnt
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   // Per-source FIFO state
   logic [PW-1:0]  wr_ptr_q   [N_SRC];
   logic [PW-1:0]  rd_ptr_q   [N_SRC];
   logic [CW-1:0]  cnt_q      [N_SRC];
   logic [4:0]     mem_rd_q   [N_SRC][DEPTH];
   logic [DW-1:0]  mem_data_q [N_SRC][DEPTH];

   // Unpacked views of the flat input buses
   logic [4:0]     in_rd   [N_SRC];
   logic [DW-1:0]  in_data [N_SRC];

   logic [N_SRC-1:0] hs;
   logic [N_SRC-1:0] push;
   logic [N_SRC-1:0] drop;
   logic [N_SRC-1:0] pop;
   logic [N_SRC-1:0] nonempty;

   // Arbitration
   logic [SW-1:0]  rr_ptr_q;
   logic [SW-1:0]  rr_next;
   logic [SW-1:0]  win;
   logic [SW:0]    idx_sum;
   logic           found;
   logic           load;
   logic [4:0]     head_rd;
   logic [DW-1:0]  head_data;

   // Drop counter
   logic [16:0]    drop_sum;
   logic [15:0]    drop_cnt_d;

   // Slice the flat source buses into per-source fields
   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         in_rd[i]   = src_rd[5*i +: 5];
         in_data[i] = src_data[DW*i +: DW];
      end
   end

   // Enqueue side: ready depends only on registered count, so a full FIFO never passes through
   always_comb begin
      src_ready = '0;
      hs        = '0;
      push      = '0;
      drop      = '0;
      nonempty  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         src_ready[i] = (cnt_q[i] < CW'(DEPTH));
         hs[i]        = src_valid[i] & src_ready[i];
         push[i]      = hs[i] & (in_rd[i] != 5'd0);
         drop[i]      = hs[i] & (in_rd[i] == 5'd0);
         nonempty[i]  = (cnt_q[i] != '0);
      end
   end

   // Round-robin search starting at rr_ptr, wrapping at N_SRC
   always_comb begin
      found   = 1'b0;
      win     = '0;
      idx_sum = '0;
      for (int k = 0; k < N_SRC; k++) begin
         idx_sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
         if (idx_sum >= (SW+1)'(N_SRC)) begin
            idx_sum = idx_sum - (SW+1)'(N_SRC);
         end
         if (!found && nonempty[idx_sum[SW-1:0]]) begin
            found = 1'b1;
            win   = idx_sum[SW-1:0];
         end
      end
   end

   // Output register reloads when empty or when the consumer takes the current beat
   always_comb begin
      load      = !cdb_valid | cdb_ready;
      head_rd   = mem_rd_q[win][rd_ptr_q[win]];
      head_data = mem_data_q[win][rd_ptr_q[win]];
      rr_next   = (win == SW'(N_SRC - 1)) ? '0 : win + SW'(1);
      pop       = '0;
      for (int i = 0; i < N_SRC; i++) begin
         pop[i] = load & found & (win == SW'(i));
      end
   end

   // Saturating sum of all r0 drops this cycle
   always_comb begin
      drop_sum = {1'b0, drop_cnt};
      for (int i = 0; i < N_SRC; i++) begin
         drop_sum = drop_sum + 17'(drop[i]);
      end
      drop_cnt_d = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SRC; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
               wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
               rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
            end
            cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         end
      end
   end

   // FIFO storage; contents are meaningless until the pointers say otherwise, so no reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SRC; i++) begin
         if (push[i]) begin
            mem_rd_q[i][wr_ptr_q[i]]   <= in_rd[i];
            mem_data_q[i][wr_ptr_q[i]] <= in_data[i];
         end
      end
   end

   // CDB register and round-robin pointer; payload holds when nothing is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_valid <= 1'b0;
         cdb_src   <= '0;
         cdb_rd    <= '0;
         cdb_data  <= '0;
         rr_ptr_q  <= '0;
      end else if (load) begin
         if (found) begin
            cdb_valid <= 1'b1;
            cdb_src   <= win;
            cdb_rd    <= head_rd;
            cdb_data  <= head_data;
            rr_ptr_q  <= rr_next;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

   // Count of discarded r0 results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Directed bench for wb_cdb_arbiter: reset, latency, round-robin order, back-pressure,
// r0 drops with saturation, and a randomised stress run against a per-source queue model.
module tb_wb_cdb_arbiter;

   localparam int N  = 8;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    src_valid = '0;
   logic [N-1:0]    src_ready;
   logic [5*N-1:0]  src_rd = '0;
   logic [DW*N-1:0] src_data = '0;
   logic            cdb_valid;
   logic            cdb_ready = 1'b1;
   logic [2:0]      cdb_src;
   logic [4:0]      cdb_rd;
   logic [DW-1:0]   cdb_data;
   logic [15:0]     drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic [36:0] exp_q [N][$];
   int          wait_cnt [N];

   wb_cdb_arbiter #(.N_SRC(8), .DW(32), .DEPTH(2), .SW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_rd    (src_rd),
      .src_data  (src_data),
      .cdb_valid (cdb_valid),
      .cdb_ready (cdb_ready),
      .cdb_src   (cdb_src),
      .cdb_rd    (cdb_rd),
      .cdb_data  (cdb_data),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      src_valid = '0;
      src_rd    = '0;
      src_data  = '0;
      cdb_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send(input int i, input logic [4:0] rd, input logic [31:0] d);
      src_valid[i]      = 1'b1;
      src_rd[5*i +: 5]  = rd;
      src_data[32*i +: 32] = d;
   endtask

   // Stress-run observer: retire an accepted beat against the model, then record handshakes
   task automatic observe(input bit allow_push);
      logic [36:0] e;
      int s;
      if (cdb_valid && cdb_ready) begin
         s = int'(cdb_src);
         if (exp_q[s].size() == 0) begin
            check("s6_extra_beat", 64'(cdb_src), 64'hFF);
         end else begin
            e = exp_q[s].pop_front();
            check("s6_beat", 64'({cdb_rd, cdb_data}), 64'(e));
         end
         for (int j = 0; j < N; j++) begin
            if (j == s || exp_q[j].size() == 0) wait_cnt[j] = 0;
            else wait_cnt[j]++;
            check("s6_fair", 64'(wait_cnt[j] <= N), 64'd1);
         end
      end
      if (allow_push) begin
         for (int i = 0; i < N; i++) begin
            if (src_valid[i] && src_ready[i] && src_rd[5*i +: 5] != 5'd0) begin
               exp_q[i].push_back({src_rd[5*i +: 5], src_data[32*i +: 32]});
            end
         end
      end
   endtask

   initial begin
      // 1. Reset then idle
      do_reset();
      check("t1_ready", 64'(src_ready), 64'hFF);
      check("t1_valid", 64'(cdb_valid), 64'd0);
      check("t1_drop", 64'(drop_cnt), 64'd0);

      // 2. Single result, two-cycle latency
      send(2, 5'd5, 32'hDEADBEEF);
      step();
      src_valid = '0;
      check("t2_c1_valid", 64'(cdb_valid), 64'd0);
      step();
      check("t2_c2_valid", 64'(cdb_valid), 64'd1);
      check("t2_c2_src", 64'(cdb_src), 64'd2);
      check("t2_c2_rd", 64'(cdb_rd), 64'd5);
      check("t2_c2_data", 64'(cdb_data), 64'hDEADBEEF);
      step();
      check("t2_c3_valid", 64'(cdb_valid), 64'd0);

      // 1b. Asynchronous reset while the CDB holds a result
      send(2, 5'd7, 32'h11111111);
      send(5, 5'd8, 32'h22222222);
      step();
      src_valid = '0;
      step();
      check("t1b_valid_pre", 64'(cdb_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t1b_valid_async", 64'(cdb_valid), 64'd0);
      check("t1b_data_async", 64'(cdb_data), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t1b_no_stale", 64'(cdb_valid), 64'd0);
      end

      // 3. Round-robin order 0,3,7 then wrap to 0,3
      do_reset();
      send(0, 5'd1, 32'h100);
      send(3, 5'd4, 32'h103);
      send(7, 5'd8, 32'h107);
      step();
      src_valid = '0;
      step();
      check("t3_b0_src", 64'(cdb_src), 64'd0);
      check("t3_b0_data", 64'(cdb_data), 64'h100);
      step();
      check("t3_b1_src", 64'(cdb_src), 64'd3);
      check("t3_b1_rd", 64'(cdb_rd), 64'd4);
      step();
      check("t3_b2_src", 64'(cdb_src), 64'd7);
      check("t3_b2_data", 64'(cdb_data), 64'h107);
      send(0, 5'd2, 32'h200);
      send(3, 5'd3, 32'h203);
      step();
      src_valid = '0;
      check("t3_gap_valid", 64'(cdb_valid), 64'd0);
      step();
      check("t3_b3_src", 64'(cdb_src), 64'd0);
      step();
      check("t3_b4_src", 64'(cdb_src), 64'd3);
      check("t3_b4_data", 64'(cdb_data), 64'h203);
      step();
      check("t3_idle", 64'(cdb_valid), 64'd0);

      // 4. Back-pressure and full FIFO
      do_reset();
      cdb_ready = 1'b0;
      send(1, 5'd9, 32'd1);
      step();
      send(1, 5'd9, 32'd2);
      check("t4_c1_ready", 64'(src_ready[1]), 64'd1);
      step();
      check("t4_c2_valid", 64'(cdb_valid), 64'd1);
      check("t4_c2_data", 64'(cdb_data), 64'd1);
      check("t4_c2_ready", 64'(src_ready[1]), 64'd1);
      send(1, 5'd9, 32'd3);
      step();
      check("t4_c3_full", 64'(src_ready[1]), 64'd0);
      send(1, 5'd9, 32'd4);
      step();
      check("t4_c4_full", 64'(src_ready[1]), 64'd0);
      check("t4_c4_hold", 64'(cdb_data), 64'd1);
      cdb_ready = 1'b1;
      step();
      check("t4_c5_data", 64'(cdb_data), 64'd2);
      check("t4_c5_ready", 64'(src_ready[1]), 64'd1);
      step();
      src_valid = '0;
      check("t4_c6_data", 64'(cdb_data), 64'd3);
      step();
      check("t4_c7_data", 64'(cdb_data), 64'd4);
      check("t4_c7_valid", 64'(cdb_valid), 64'd1);
      step();
      check("t4_c8_valid", 64'(cdb_valid), 64'd0);

      // 5. r0 drops and saturation
      do_reset();
      send(4, 5'd0, 32'hABCD);
      for (int k = 0; k < 5; k++) begin
         check("t5_ready", 64'(src_ready[4]), 64'd1);
         check("t5_no_beat", 64'(cdb_valid), 64'd0);
         step();
      end
      src_valid = '0;
      check("t5_drop5", 64'(drop_cnt), 64'd5);
      check("t5_no_beat_end", 64'(cdb_valid), 64'd0);
      src_rd    = '0;
      src_valid = 8'hFF;
      repeat (8191) step();
      src_valid = '0;
      check("t5_drop_bulk", 64'(drop_cnt), 64'd65533);
      src_valid = 8'h30;
      step();
      src_valid = '0;
      check("t5_drop_max", 64'(drop_cnt), 64'hFFFF);
      src_valid = 8'hFF;
      step();
      src_valid = '0;
      check("t5_drop_sat", 64'(drop_cnt), 64'hFFFF);
      check("t5_no_beat_sat", 64'(cdb_valid), 64'd0);

      // 6. Saturation stress against the queue model
      do_reset();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         for (int i = 0; i < N; i++) begin
            src_rd[5*i +: 5]     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            src_data[32*i +: 32] = $urandom;
         end
         src_valid = 8'hFF;
         cdb_ready = ($urandom_range(0, 3) != 0);
         observe(1'b1);
         step();
      end
      src_valid = '0;
      cdb_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         observe(1'b0);
         step();
      end
      for (int i = 0; i < N; i++) begin
         check("s6_left", 64'(exp_q[i].size()), 64'd0);
      end
      check("s6_idle", 64'(cdb_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
